// File: rtl/conv_layer_single_pkg.sv
// Shared sizes and controller state encoding for the single-layer 5x5 convolution engine.
package conv_layer_single_pkg;
  localparam int IMG_DIM = 32;
  localparam int K_DIM   = 5;
  localparam int OUT_DIM = 28;
  localparam int DATA_W  = 32;
  localparam int N_LANES = 14;
  localparam int N_TAPS  = 25;
  localparam int N_BATCH = 56;
  localparam int N_OUT   = OUT_DIM * OUT_DIM;

  typedef enum logic [1:0] {S_CLEAR, S_MAC, S_WRITE, S_DONE} state_e;
endpackage

// File: rtl/conv_layer_single_fp_mac.sv
// Combinational single-precision a*b+acc: each step truncated toward zero,
// exp-0 operands read as zero, underflow flushes to +0, overflow saturates to signed inf.
module fp_mac
  import conv_layer_single_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_acc,
  output logic [DATA_W-1:0] o_res
);
  logic [24:0]       w_ph;
  logic signed [9:0] w_pe;
  logic [22:0]       w_pfrac;
  logic [31:0]       w_p;
  logic [31:0]       w_big;
  logic [31:0]       w_sml;
  logic [7:0]        w_d;
  logic [26:0]       w_ys;
  logic [26:0]       w_bf;
  logic              w_st;
  logic [27:0]       w_sum;
  logic [22:0]       w_frac;
  int                w_lead;
  int                w_e;

  always_comb begin
    w_ph    = 25'((48'({1'b1, i_a[22:0]}) * 48'({1'b1, i_b[22:0]})) >> 23);
    w_pe    = $signed({2'b00, i_a[30:23]}) + $signed({2'b00, i_b[30:23]})
              - 10'sd127 + $signed({9'd0, w_ph[24]});
    w_pfrac = w_ph[24] ? w_ph[23:1] : w_ph[22:0];
    if (i_a[30:23] == 8'd0 || i_b[30:23] == 8'd0 || w_pe <= 10'sd0) w_p = '0;
    else if (w_pe >= 10'sd255) w_p = {i_a[31] ^ i_b[31], 8'hFF, 23'd0};
    else                       w_p = {i_a[31] ^ i_b[31], w_pe[7:0], w_pfrac};
  end

  // Three guard bits plus a sticky borrow make the difference an exact floor,
  // so the final 24-bit cut is a true truncation of the exact sum.
  always_comb begin
    if (w_p[30:0] >= i_acc[30:0]) begin
      w_big = w_p;
      w_sml = i_acc;
    end else begin
      w_big = i_acc;
      w_sml = w_p;
    end
    w_d  = w_big[30:23] - w_sml[30:23];
    w_ys = {1'b1, w_sml[22:0], 3'b000};
    if (w_d >= 8'd27) begin
      w_bf = '0;
      w_st = 1'b1;
    end else begin
      w_bf = w_ys >> w_d;
      w_st = |(w_ys & ((27'd1 << w_d) - 27'd1));
    end
    if (w_big[31] == w_sml[31]) w_sum = {2'b01, w_big[22:0], 3'b000} + {1'b0, w_bf};
    else                        w_sum = {2'b01, w_big[22:0], 3'b000} - {1'b0, w_bf} - 28'(w_st);
    w_lead = 0;
    for (int q = 0; q < 28; q++) if (w_sum[q]) w_lead = q;
    w_frac = 23'((w_sum << (27 - w_lead)) >> 4);
    w_e    = int'(w_big[30:23]) + w_lead - 26;
    if (w_sml[30:23] == 8'd0)          o_res = (w_big[30:23] == 8'd0) ? '0 : w_big;
    else if (w_sum == '0 || w_e <= 0)  o_res = '0;
    else if (w_e >= 255)               o_res = {w_big[31], 8'hFF, 23'd0};
    else                               o_res = {w_big[31], w_e[7:0], w_frac};
  end
endmodule

// File: rtl/conv_layer_single.sv
// 32x32 * 5x5 valid convolution: 14 MAC lanes sweep 56 batches of outputs,
// 27 cycles per batch (clear, 25 taps, write), starting on reset release.
module conv_layer_single
  import conv_layer_single_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [IMG_DIM*IMG_DIM*DATA_W-1:0]    image,
  input  logic [K_DIM*K_DIM*DATA_W-1:0]        filter,
  output logic [N_OUT*DATA_W-1:0]              outputConv
);
  state_e                           r_state;
  state_e                           w_next;
  logic [5:0]                       r_batch;
  logic [4:0]                       r_tap;
  logic [N_LANES-1:0][DATA_W-1:0]   r_acc;
  logic [N_LANES-1:0][DATA_W-1:0]   w_mac;
  logic [N_OUT-1:0][DATA_W-1:0]     r_out;
  logic [9:0]                       w_base;
  logic [4:0]                       w_i;
  logic [4:0]                       w_j;
  logic [DATA_W-1:0]                w_wt;

  assign outputConv = r_out;
  assign w_base     = 10'(r_batch) * 10'(N_LANES);
  assign w_i        = r_tap / 5'(K_DIM);
  assign w_j        = r_tap % 5'(K_DIM);
  // Weight index i*5+j is the tap number itself.
  assign w_wt       = filter[{r_tap, 5'b00000} +: DATA_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_CLEAR;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: w_next = S_MAC;
      S_MAC:   if (r_tap == 5'(N_TAPS - 1)) w_next = S_WRITE;
      S_WRITE: w_next = (r_batch == 6'(N_BATCH - 1)) ? S_DONE : S_CLEAR;
      default: w_next = S_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_batch <= '0;
      r_tap   <= '0;
      r_acc   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_acc <= '0;
          r_tap <= '0;
        end
        S_MAC: begin
          r_acc <= w_mac;
          r_tap <= (r_tap == 5'(N_TAPS - 1)) ? 5'd0 : r_tap + 5'd1;
        end
        S_WRITE: begin
          for (int k = 0; k < N_LANES; k++) r_out[w_base + 10'(k)] <= r_acc[k];
          if (r_batch != 6'(N_BATCH - 1)) r_batch <= r_batch + 6'd1;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic [9:0] w_n;
    logic [4:0] w_r;
    logic [4:0] w_c;
    logic [9:0] w_pidx;

    assign w_n    = w_base + 10'(k);
    assign w_r    = 5'(w_n / 10'(OUT_DIM));
    assign w_c    = 5'(w_n % 10'(OUT_DIM));
    assign w_pidx = {w_r + w_i, w_c + w_j};

    fp_mac u_mac (
      .i_a   (image[{w_pidx, 5'b00000} +: DATA_W]),
      .i_b   (w_wt),
      .i_acc (r_acc[k]),
      .o_res (w_mac[k])
    );
  end
endmodule

// File: tb/tb_conv_layer_single.sv
// Bench: real-valued convolution model (exact stimulus values) plus the batch write
// schedule, checked against outputConv every cycle, with literal anchors.
module tb_conv_layer_single;
  logic           clk = 1'b0;
  logic           reset;
  logic [32767:0] image;
  logic [799:0]   filter;
  logic [25087:0] outputConv;

  conv_layer_single dut (
    .clk        (clk),
    .reset      (reset),
    .image      (image),
    .filter     (filter),
    .outputConv (outputConv)
  );

  always #5 clk = ~clk;

  real            pix [32][32];
  real            wt  [5][5];
  logic [31:0]    exp_val [784];
  logic [25087:0] exp_vec;
  int             cyc = 0;
  bit             chk_en;
  int             checks;
  int             errors;

  function automatic logic [31:0] f2b(real v);
    real m;
    int  e;
    logic s;
    logic [22:0] fr;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    fr = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, 8'(e + 127), fr};
  endfunction

  function automatic void build_model();
    real acc;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) begin
        acc = 0.0;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++) acc = acc + pix[r+i][c+j] * wt[i][j];
        exp_val[r*28+c] = f2b(acc);
      end
  endfunction

  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Batch b is visible once 27*(b+1) edges have passed since release.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (outputConv !== '0) begin
        errors++;
        $display("FAIL reset_zero: outputConv not all zero at %0t", $time);
      end
    end else if (chk_en) begin
      for (int n = 0; n < 784; n++)
        exp_vec[n*32 +: 32] = (cyc >= 27*(n/14+1)) ? exp_val[n] : 32'h0;
      checks++;
      if (outputConv !== exp_vec) begin
        int fn;
        fn = 0;
        for (int n = 783; n >= 0; n--) if (outputConv[n*32 +: 32] !== exp_vec[n*32 +: 32]) fn = n;
        errors++;
        $display("FAIL sched_cmp: cyc=%0d out[%0d] got %h want %h", cyc, fn,
                 outputConv[fn*32 +: 32], exp_vec[fn*32 +: 32]);
      end
    end
  end

  task automatic check_lit(string nm, int n, logic [31:0] want);
    checks++;
    if (outputConv[n*32 +: 32] !== want) begin
      errors++;
      $display("FAIL %s: out[%0d] got %h want %h", nm, n, outputConv[n*32 +: 32], want);
    end
  endtask

  task automatic check_model(string nm, int n, logic [31:0] want);
    checks++;
    if (exp_val[n] !== want) begin
      errors++;
      $display("FAIL %s: model[%0d] got %h want %h", nm, n, exp_val[n], want);
    end
  endtask

  task automatic hold_reset(int n, bit rnd);
    @(negedge clk); #2;
    reset  = 1'b0;
    chk_en = 1'b0;
    repeat (n) begin
      if (rnd) begin
        for (int w = 0; w < 1024; w++) image[w*32 +: 32] = $urandom;
        for (int w = 0; w < 25; w++)   filter[w*32 +: 32] = $urandom;
      end
      @(negedge clk);
    end
  endtask

  task automatic release_run(int ncyc);
    build_model();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) image[(r*32+c)*32 +: 32] = f2b(pix[r][c]);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) filter[(i*5+j)*32 +: 32] = f2b(wt[i][j]);
    @(negedge clk); #2;
    reset  = 1'b1;
    chk_en = 1'b1;
    repeat (ncyc) @(negedge clk);
    #1;
  endtask

  task automatic set_ones_case();
    for (int r = 0; r < 32; r++) for (int c = 0; c < 32; c++) pix[r][c] = 4.0;
    pix[31][31] = 1.0;
    for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) wt[i][j] = 4.0;
  endtask

  initial begin
    reset  = 1'b0;
    image  = '0;
    filter = '0;
    chk_en = 1'b0;
    checks = 0;
    errors = 0;

    // Uniform 4.0 with one 1.0 corner pixel; random inputs while held in reset.
    set_ones_case();
    hold_reset(5, 1'b1);
    release_run(26);
    check_lit("out0_cycle26", 0, 32'h0);
    @(negedge clk); #1;
    check_lit("out0_cycle27", 0, 32'h43C80000);
    repeat (1490) @(negedge clk);
    #1;
    check_model("model_400", 0, 32'h43C80000);
    check_model("model_388", 783, 32'h43C20000);
    check_lit("res_400_mid", 500, 32'h43C80000);
    check_lit("res_400_782", 782, 32'h43C80000);
    check_lit("res_388_last", 783, 32'h43C20000);

    // Single centre tap picks out shifted pixel indices.
    for (int r = 0; r < 32; r++) for (int c = 0; c < 32; c++) pix[r][c] = real'(r*32 + c);
    for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) wt[i][j] = 0.0;
    wt[2][2] = 1.0;
    hold_reset(3, 1'b0);
    release_run(1515);
    check_model("model_centre", 0, 32'h42840000);
    check_lit("centre_00", 0, 32'h42840000);
    check_lit("centre_last", 783, 32'h446F4000);

    // Negative weights, then all-zero filter.
    for (int r = 0; r < 32; r++) for (int c = 0; c < 32; c++) pix[r][c] = 2.0;
    for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) wt[i][j] = -1.0;
    hold_reset(2, 1'b0);
    release_run(1515);
    check_lit("neg50", 100, 32'hC2480000);
    for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) wt[i][j] = 0.0;
    hold_reset(2, 1'b0);
    release_run(1515);
    check_lit("zero_filter", 400, 32'h0);

    // Random eighths in [-8,8]: every product and partial sum stays exact.
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++) pix[r][c] = real'(int'($urandom_range(128)) - 64) / 8.0;
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) wt[i][j] = real'(int'($urandom_range(128)) - 64) / 8.0;
      hold_reset(2, 1'b0);
      release_run(1515);
    end

    // Abort at cycle 700, then a full restart of the schedule.
    set_ones_case();
    hold_reset(2, 1'b0);
    release_run(700);
    reset = 1'b0;
    #1;
    checks++;
    if (outputConv !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: outputConv not zero right after reset assert");
    end
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (1515) @(negedge clk);
    #1;
    check_lit("restart_400", 0, 32'h43C80000);
    check_lit("restart_388", 783, 32'h43C20000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
